// File: rtl/full_subtractor_pkg.sv
// Shared constants for the registered ripple-borrow subtractor.
// Optional FULLSUB_FLAGS_EN build adds registered Zero/Ovf flags.
package full_subtractor_pkg;

    // Widest supported operand
    localparam int WIDTH_MAX = 64;

    // Reset image of the {Bout, Diff} result register
    localparam logic [WIDTH_MAX:0] RES_RST = '0;

    // Flag register reset image {Ovf, Zero}
    localparam logic [1:0] FLG_RST = 2'b00;

endpackage

// File: rtl/full_subtractor_if.sv
// Operand/result bundle for full_subtractor_df.
// FULLSUB_FLAGS_EN adds the Zero and Ovf result flags.
interface full_subtractor_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
`ifdef FULLSUB_FLAGS_EN
    logic             Zero;
    logic             Ovf;

    modport master (
        output A, B, Bin,
        input  Diff, Bout, Zero, Ovf
    );
    modport slave (
        input  A, B, Bin,
        output Diff, Bout, Zero, Ovf
    );
`else
    modport master (
        output A, B, Bin,
        input  Diff, Bout
    );
    modport slave (
        input  A, B, Bin,
        output Diff, Bout
    );
`endif
endinterface

// File: rtl/full_subtractor_cell.sv
// One-bit dataflow full subtractor: d = a - b - bin.
// Purely combinational; chained by the top to form the borrow ripple.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/full_subtractor_df.sv
// Registered WIDTH-bit ripple-borrow subtractor, one-cycle latency.
// FULLSUB_FLAGS_EN adds registered Zero and signed-overflow flags.
module full_subtractor_df
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input logic              clk,
    input logic              rst,
    full_subtractor_if.slave io
);
    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("full_subtractor_df: WIDTH out of range");
    end

    // b[i] is the borrow into cell i; b[WIDTH] leaves the MSB
    logic [WIDTH:0]   b;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   res_q;

    assign b[0] = io.Bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor_cell u_cell (
            .a    (io.A[i]),
            .b    (io.B[i]),
            .bin  (b[i]),
            .d    (d[i]),
            .bout (b[i+1])
        );
    end

    // Capture {borrow-out, difference}; reset drops any pending result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= RES_RST[WIDTH:0];
        end else begin
            res_q <= {b[WIDTH], d};
        end
    end

    assign io.Diff = res_q[WIDTH-1:0];
    assign io.Bout = res_q[WIDTH];

`ifdef FULLSUB_FLAGS_EN
    logic [1:0] flg_q;
    logic       zero_c;
    logic       ovf_c;

    assign zero_c = ~|d;
    // Signed overflow: carry into and out of the sign cell disagree
    assign ovf_c  = b[WIDTH] ^ b[WIDTH-1];

    // Register flags alongside the result so they share its latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flg_q <= FLG_RST;
        end else begin
            flg_q <= {ovf_c, zero_c};
        end
    end

    assign io.Zero = flg_q[0];
    assign io.Ovf  = flg_q[1];
`endif

endmodule

// File: tb/tb_full_subtractor_df.sv
// Directed and random checks of full_subtractor_df at WIDTH 1, 4 and 8.
// Flag checks run only when FULLSUB_FLAGS_EN is defined.
module tb_full_subtractor_df;

    logic clk;
    logic rst;

    int n_err;
    int n_chk;

    full_subtractor_if #(.WIDTH(1)) if1 ();
    full_subtractor_if #(.WIDTH(4)) if4 ();
    full_subtractor_if #(.WIDTH(8)) if8 ();

    full_subtractor_df #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .io  (if1.slave)
    );
    full_subtractor_df #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .io  (if4.slave)
    );
    full_subtractor_df #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .io  (if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic a, input logic bb,
                          input logic bi);
        if1.A   = a;
        if1.B   = bb;
        if1.Bin = bi;
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] bb,
                          input logic bi);
        if4.A   = a;
        if4.B   = bb;
        if4.Bin = bi;
    endtask

    logic [7:0] tt_d;
    logic [7:0] tt_b;
    logic [2:0] v;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbi;
    logic [8:0] exp8;

    initial begin
        n_err = 0;
        n_chk = 0;
        // Truth table columns indexed by {A,B,Bin}
        tt_d = 8'b1001_0110;
        tt_b = 8'b1000_1110;

        rst = 1'b1;
        drive1(1'b0, 1'b0, 1'b0);
        drive4(4'h0, 4'h0, 1'b0);
        if8.A   = '0;
        if8.B   = '0;
        if8.Bin = 1'b0;

        #12;
        check("rst_d1", 64'(if1.Diff), 64'd0);
        check("rst_b1", 64'(if1.Bout), 64'd0);
        check("rst_d4", 64'(if4.Diff), 64'd0);
        check("rst_b8", 64'(if8.Bout), 64'd0);
`ifdef FULLSUB_FLAGS_EN
        check("rst_zero4", 64'(if4.Zero), 64'd0);
        check("rst_ovf4", 64'(if4.Ovf), 64'd0);
`endif
        rst = 1'b0;

        // Exhaustive one-bit truth table
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            drive1(v[2], v[1], v[0]);
            cyc();
            check($sformatf("tt%0d_d", i), 64'(if1.Diff), 64'(tt_d[v]));
            check($sformatf("tt%0d_b", i), 64'(if1.Bout), 64'(tt_b[v]));
        end

        // Latency: new inputs must not show before the edge
        drive1(1'b1, 1'b0, 1'b0);
        cyc();
        drive1(1'b0, 1'b1, 1'b1);
        #2;
        check("lat_pre_d", 64'(if1.Diff), 64'd1);
        check("lat_pre_b", 64'(if1.Bout), 64'd0);
        cyc();
        check("lat_post_d", 64'(if1.Diff), 64'd0);
        check("lat_post_b", 64'(if1.Bout), 64'd1);

        // Asynchronous reset between edges
        drive1(1'b1, 1'b1, 1'b1);
        cyc();
        check("ar_hold_d", 64'(if1.Diff), 64'd1);
        check("ar_hold_b", 64'(if1.Bout), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_async_d", 64'(if1.Diff), 64'd0);
        check("ar_async_b", 64'(if1.Bout), 64'd0);
        cyc();
        check("ar_held_d", 64'(if1.Diff), 64'd0);
        check("ar_held_b", 64'(if1.Bout), 64'd0);
        #2;
        rst = 1'b0;
        drive1(1'b1, 1'b0, 1'b0);
        cyc();
        check("ar_after_d", 64'(if1.Diff), 64'd1);
        check("ar_after_b", 64'(if1.Bout), 64'd0);

        // Four-bit directed vectors
        drive4(4'h3, 4'h5, 1'b0);
        cyc();
        check("w4_a_d", 64'(if4.Diff), 64'hE);
        check("w4_a_b", 64'(if4.Bout), 64'd1);
        drive4(4'h9, 4'h2, 1'b1);
        cyc();
        check("w4_b_d", 64'(if4.Diff), 64'h6);
        check("w4_b_b", 64'(if4.Bout), 64'd0);
        drive4(4'h0, 4'hF, 1'b1);
        cyc();
        check("w4_c_d", 64'(if4.Diff), 64'h0);
        check("w4_c_b", 64'(if4.Bout), 64'd1);
        drive4(4'h7, 4'h7, 1'b1);
        cyc();
        check("w4_eq_d", 64'(if4.Diff), 64'hF);
        check("w4_eq_b", 64'(if4.Bout), 64'd1);

`ifdef FULLSUB_FLAGS_EN
        drive4(4'h8, 4'h1, 1'b0);
        cyc();
        check("fl_a_d", 64'(if4.Diff), 64'h7);
        check("fl_a_ovf", 64'(if4.Ovf), 64'd1);
        check("fl_a_zero", 64'(if4.Zero), 64'd0);
        drive4(4'h5, 4'h5, 1'b0);
        cyc();
        check("fl_b_zero", 64'(if4.Zero), 64'd1);
        check("fl_b_ovf", 64'(if4.Ovf), 64'd0);
`endif

        // Eight-bit random regression, one vector per cycle
        ra  = 8'($urandom_range(0, 255));
        rb  = 8'($urandom_range(0, 255));
        rbi = 1'($urandom_range(0, 1));
        for (int i = 0; i < 1000; i++) begin
            if8.A   = ra;
            if8.B   = rb;
            if8.Bin = rbi;
            exp8 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            cyc();
            check("w8_rand", 64'({if8.Bout, if8.Diff}), 64'(exp8));
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
